// File: rtl/pair_bit_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : pair_bit_dispatcher
// Brief    : Accepts a request vector over valid/ready and drains it two set
//            bits per beat (lowest, then second-lowest) as binary indices to a
//            dual-issue consumer. Counts fully drained vectors.
// Revision : 1.0 - initial release
// ============================================================================
module pair_bit_dispatcher #(
    parameter int WIDTH = 12,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vec_valid_i,
    output logic             vec_ready_o,
    input  logic [WIDTH-1:0] vec_i,
    output logic             disp_valid_o,
    input  logic             disp_ready_i,
    output logic [IDX_W-1:0] idx0_o,
    output logic [IDX_W-1:0] idx1_o,
    output logic             idx1_vld_o,
    output logic             last_o,
    output logic [CNT_W-1:0] done_cnt_o
);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_DISPATCH = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] C_VEC_ONE = WIDTH'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_pending;
    logic [WIDTH-1:0]   w_pending_nxt;
    logic [CNT_W-1:0]   r_done_cnt;
    logic [CNT_W-1:0]   w_done_cnt_nxt;

    logic [WIDTH-1:0]   w_first;
    logic [WIDTH-1:0]   w_rest;
    logic [WIDTH-1:0]   w_second;
    logic [WIDTH-1:0]   w_remain;
    logic [IDX_W-1:0]   w_idx0;
    logic [IDX_W-1:0]   w_idx1;
    logic               w_is_last;

    // Isolate the two lowest set bits of the pending vector as one-hot masks
    // (x & -x keeps only the lowest set bit) and what remains after this beat.
    always_comb begin
        w_first   = r_pending & (~r_pending + C_VEC_ONE);
        w_rest    = r_pending & ~w_first;
        w_second  = w_rest & (~w_rest + C_VEC_ONE);
        w_remain  = w_rest & ~w_second;
        w_is_last = (w_remain == '0);
    end

    // Binary-encode the two one-hot masks; an all-zero mask encodes to 0.
    always_comb begin
        w_idx0 = '0;
        w_idx1 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_first[i]) begin
                w_idx0 = IDX_W'(i);
            end
            if (w_second[i]) begin
                w_idx1 = IDX_W'(i);
            end
        end
    end

    // Next-state and output decode; outputs depend only on registered state
    // and pending, so no input ever reaches an output combinationally.
    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_done_cnt_nxt = r_done_cnt;
        vec_ready_o    = 1'b0;
        disp_valid_o   = 1'b0;
        idx0_o         = '0;
        idx1_o         = '0;
        idx1_vld_o     = 1'b0;
        last_o         = 1'b0;

        case (r_state)
            S_IDLE: begin
                vec_ready_o = 1'b1;
                // An all-zero vector has nothing to dispatch and is dropped.
                if (vec_valid_i && (vec_i != '0)) begin
                    w_pending_nxt = vec_i;
                    w_state_nxt   = S_DISPATCH;
                end
            end

            S_DISPATCH: begin
                disp_valid_o = 1'b1;
                idx0_o       = w_idx0;
                idx1_vld_o   = (w_second != '0);
                idx1_o       = (w_second != '0) ? w_idx1 : '0;
                last_o       = w_is_last;
                if (disp_ready_i) begin
                    w_pending_nxt = w_remain;
                    if (w_is_last) begin
                        w_state_nxt    = S_IDLE;
                        w_done_cnt_nxt = r_done_cnt + C_CNT_ONE;
                    end
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending-bit vector and drained-vector counter; reset discards any
    // partially dispatched vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_done_cnt <= '0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_done_cnt <= w_done_cnt_nxt;
        end
    end

    assign done_cnt_o = r_done_cnt;

endmodule
`default_nettype wire
